// File: rtl/arv_mem_arbiter_if.sv
// Unified memory port of arv_mem_arbiter: request/ready plus a read-data return channel.
// The arbiter drives the master modport and the memory model/controller the slave modport.
interface arv_mem_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/arv_mem_arbiter.sv
// Fetch/load/store arbiter onto one single-ported memory, one access outstanding at a time.
// Define ARB_STATS_EN to add the grant and stall counters (if_cnt, ld_cnt, st_cnt, stall_cnt).
module arv_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    input  logic              st_req,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_gnt,
    arv_mem_arbiter_if.master mem,
    output logic              busy,
    output logic              err_spurious
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       if_cnt,
    output logic [31:0]       ld_cnt,
    output logic [31:0]       st_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic [1:0] {OWN_IF = 2'd0, OWN_LD = 2'd1, OWN_ST = 2'd2} owner_t;

    state_t      state;
    owner_t      owner;
    owner_t      winner;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic [3:0]  starve_cnt;
    logic        issue;
    logic        accept;
    logic        data_gnt;

    // The bus is only driven while a transaction is being issued; it reads as zero otherwise.
    assign issue         = (state == ISSUE);
    assign accept        = issue & mem.mem_ready;
    assign mem.mem_req   = issue;
    assign mem.mem_we    = issue & we_q;
    assign mem.mem_addr  = issue ? addr_q : '0;
    assign mem.mem_wdata = (issue & we_q) ? wdata_q : '0;
    assign mem.mem_size  = issue ? size_q : '0;

    assign if_gnt   = accept & (owner == OWN_IF);
    assign ld_gnt   = accept & (owner == OWN_LD);
    assign st_gnt   = accept & (owner == OWN_ST);
    assign data_gnt = ld_gnt | st_gnt;
    assign busy     = (state != IDLE);

    // Store beats load beats fetch, unless fetch has waited through LIMIT data grants.
    always_comb begin
        winner = OWN_IF;
        if (!(if_req && (starve_cnt == LIMIT))) begin
            if (st_req) begin
                winner = OWN_ST;
            end else if (ld_req) begin
                winner = OWN_LD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= OWN_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            starve_cnt   <= '0;
            if_rvalid    <= 1'b0;
            ld_rvalid    <= 1'b0;
            if_rdata     <= '0;
            ld_rdata     <= '0;
            err_spurious <= 1'b0;
`ifdef ARB_STATS_EN
            if_cnt       <= '0;
            ld_cnt       <= '0;
            st_cnt       <= '0;
            stall_cnt    <= '0;
`endif
        end else begin
            if_rvalid    <= 1'b0;
            ld_rvalid    <= 1'b0;
            err_spurious <= mem.mem_rvalid & (state != WAIT);

            case (state)
                IDLE: begin
                    if (if_req | ld_req | st_req) begin
                        owner <= winner;
                        state <= ISSUE;
                        case (winner)
                            OWN_ST: begin
                                addr_q  <= st_addr;
                                wdata_q <= st_data;
                                size_q  <= st_size;
                                we_q    <= 1'b1;
                            end
                            OWN_LD: begin
                                addr_q  <= ld_addr;
                                wdata_q <= '0;
                                size_q  <= 2'b10;
                                we_q    <= 1'b0;
                            end
                            default: begin
                                addr_q  <= if_addr;
                                wdata_q <= '0;
                                size_q  <= 2'b10;
                                we_q    <= 1'b0;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    if (mem.mem_ready) begin
                        state <= we_q ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        state <= IDLE;
                        if (owner == OWN_LD) begin
                            ld_rdata  <= mem.mem_rdata;
                            ld_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem.mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (!if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (data_gnt && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

`ifdef ARB_STATS_EN
            if_cnt    <= if_cnt + 32'(if_gnt);
            ld_cnt    <= ld_cnt + 32'(ld_gnt);
            st_cnt    <= st_cnt + 32'(st_gnt);
            stall_cnt <= stall_cnt + 32'(issue & ~mem.mem_ready);
`endif
        end
    end

endmodule
